regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_rr.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, register-file constants and the writeback request type
// for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-input round-robin grant logic. The pointer only moves when both
// requesters compete, so a lone requester never disturbs fairness.
module wb_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // ptr = 1 means requester 1 is favoured at the next contended cycle
  logic ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (req0 && req1) begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (req0 && req1) begin
      ptr <= gnt0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write
// port and tracks pending destination registers for decode-stage stalls.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb0_valid,
  input  logic [ADDR_W-1:0]   wb0_reg,
  input  logic [DATA_W-1:0]   wb0_data,
  output logic                wb0_ready,
  input  logic                wb1_valid,
  input  logic [ADDR_W-1:0]   wb1_reg,
  input  logic [DATA_W-1:0]   wb1_data,
  output logic                wb1_ready,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_reg,
  input  logic [ADDR_W-1:0]   ReadRegister1,
  input  logic [ADDR_W-1:0]   ReadRegister2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteRegister,
  output logic [DATA_W-1:0]   WriteData
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic                acc0;
  logic                acc1;
  logic                acc_any;
  logic [ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] busy_next;

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (wb0_valid),
    .req1  (wb1_valid),
    .gnt0  (wb0_ready),
    .gnt1  (wb1_ready)
  );

  assign acc0    = wb0_valid && wb0_ready;
  assign acc1    = wb1_valid && wb1_ready;
  assign acc_any = acc0 || acc1;

  always_comb begin
    sel_reg  = wb0_reg;
    sel_data = wb0_data;
    if (acc1) begin
      sel_reg  = wb1_reg;
      sel_data = wb1_data;
    end
  end

  // Clear first, then set, so a same-edge reservation keeps the register busy
  always_comb begin
    busy_next = busy_vec;
    if (acc_any) begin
      busy_next[sel_reg] = 1'b0;
    end
    if (rsv_valid && (rsv_reg != ZERO_IDX)) begin
      busy_next[rsv_reg] = 1'b1;
    end
    busy_next[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

  // Writes to the zero register complete the handshake but never reach the file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (acc_any) begin
      RegWrite      <= (sel_reg != ZERO_IDX);
      WriteRegister <= sel_reg;
      WriteData     <= sel_data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  assign stall = ((ReadRegister1 != ZERO_IDX) && busy_vec[ReadRegister1]) ||
                 ((ReadRegister2 != ZERO_IDX) && busy_vec[ReadRegister2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference model predicts grants,
// busy bits and stalls, and queues the expected write for the following cycle.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb0_valid, wb1_valid, rsv_valid;
  logic [4:0]        wb0_reg, wb1_reg, rsv_reg;
  logic [63:0]       wb0_data, wb1_data;
  logic              wb0_ready, wb1_ready;
  logic [4:0]        ReadRegister1, ReadRegister2;
  logic              stall;
  logic [31:0]       busy_vec;
  logic              RegWrite;
  logic [4:0]        WriteRegister;
  logic [63:0]       WriteData;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    logic [4:0]  r;
    logic [63:0] d;
  } exp_t;

  exp_t        expQ[$];
  bit          mptr;
  logic [31:0] mbusy;
  bit          mAcc0, mAcc1;
  logic        obsR0;
  wb_req_t     p0, p1;
  bit          p0v, p1v;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .wb0_valid     (wb0_valid),
    .wb0_reg       (wb0_reg),
    .wb0_data      (wb0_data),
    .wb0_ready     (wb0_ready),
    .wb1_valid     (wb1_valid),
    .wb1_reg       (wb1_reg),
    .wb1_data      (wb1_data),
    .wb1_ready     (wb1_ready),
    .rsv_valid     (rsv_valid),
    .rsv_reg       (rsv_reg),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .stall         (stall),
    .busy_vec      (busy_vec),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge, checks at the falling
  // edge, advances the model across the next rising edge.
  task automatic applyStimulus(input bit v0, input logic [4:0] r0, input logic [63:0] d0,
                               input bit v1, input logic [4:0] r1, input logic [63:0] d1,
                               input bit rv, input logic [4:0] rr,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    exp_t        e;
    bit          g0, g1, ms;
    logic [31:0] nb;
    wb0_valid = v0; wb0_reg = r0; wb0_data = d0;
    wb1_valid = v1; wb1_reg = r1; wb1_data = d1;
    rsv_valid = rv; rsv_reg = rr;
    ReadRegister1 = rs1; ReadRegister2 = rs2;
    @(negedge clk);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("RegWrite", {63'd0, RegWrite}, {63'd0, e.we});
      if (e.we) begin
        checkOutput("WriteRegister", {59'd0, WriteRegister}, {59'd0, e.r});
        checkOutput("WriteData", WriteData, e.d);
      end
    end
    checkOutput("busy_vec", {32'd0, busy_vec}, {32'd0, mbusy});
    g0 = v0 && (!v1 || !mptr);
    g1 = v1 && !g0;
    ms = ((rs1 != 5'd31) && mbusy[rs1]) || ((rs2 != 5'd31) && mbusy[rs2]);
    checkOutput("wb0_ready", {63'd0, wb0_ready}, {63'd0, g0});
    checkOutput("wb1_ready", {63'd0, wb1_ready}, {63'd0, g1});
    checkOutput("stall", {63'd0, stall}, {63'd0, ms});
    obsR0 = wb0_ready;
    e.we = 1'b0; e.r = '0; e.d = '0;
    if (g0) begin e.we = (r0 != 5'd31); e.r = r0; e.d = d0; end
    if (g1) begin e.we = (r1 != 5'd31); e.r = r1; e.d = d1; end
    expQ.push_back(e);
    nb = mbusy;
    if (g0) nb[r0] = 1'b0;
    if (g1) nb[r1] = 1'b0;
    if (rv && rr != 5'd31) nb[rr] = 1'b1;
    nb[31] = 1'b0;
    mbusy = nb;
    if (v0 && v1) mptr = g0;
    mAcc0 = g0;
    mAcc1 = g1;
    @(posedge clk);
    #1;
  endtask

  task automatic idleStep(input logic [4:0] rs1);
    applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 5'd0, rs1, 5'd0);
  endtask

  initial begin
    reset = 1'b0;
    wb0_valid = 0; wb0_reg = '0; wb0_data = '0;
    wb1_valid = 0; wb1_reg = '0; wb1_data = '0;
    rsv_valid = 0; rsv_reg = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    mptr = 0; mbusy = '0;

    #3;
    wb0_valid = 1; wb1_valid = 1;
    #1;
    checkOutput("rst_RegWrite", {63'd0, RegWrite}, 64'd0);
    checkOutput("rst_WriteData", WriteData, 64'd0);
    checkOutput("rst_busy", {32'd0, busy_vec}, 64'd0);
    checkOutput("rst_ready0", {63'd0, wb0_ready}, 64'd0);
    checkOutput("rst_ready1", {63'd0, wb1_ready}, 64'd0);
    wb0_valid = 0; wb1_valid = 0;
    #18 reset = 1'b1;
    @(posedge clk);
    #1;

    // single request, then two idle cycles to see the write and its removal
    applyStimulus(1, 5'd5, 64'hDEAD, 0, 5'd0, 64'd0, 0, 5'd0, 5'd0, 5'd0);
    checkOutput("single_we", {63'd0, RegWrite}, 64'd1);
    idleStep(5'd0);
    idleStep(5'd0);

    // contention: loser keeps its request stable until granted
    p0 = '{reg_addr: 5'd10, data: 64'h100};
    p1 = '{reg_addr: 5'd20, data: 64'h200};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, p0.reg_addr, p0.data, 1, p1.reg_addr, p1.data, 0, 5'd0, 5'd0, 5'd0);
      checkOutput("rr_order", {63'd0, obsR0}, {63'd0, (i % 2 == 0)});
      if (mAcc0) p0 = '{reg_addr: p0.reg_addr + 5'd1, data: p0.data + 64'd1};
      if (mAcc1) p1 = '{reg_addr: p1.reg_addr + 5'd1, data: p1.data + 64'd1};
    end
    idleStep(5'd0);

    // reserve r7, stall on it, clear it with a load writeback
    applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd7, 5'd0, 5'd0);
    applyStimulus(0, 5'd0, 64'd0, 1, 5'd7, 64'h77, 0, 5'd0, 5'd7, 5'd0);
    idleStep(5'd7);
    checkOutput("r7_cleared", {63'd0, busy_vec[7]}, 64'd0);

    // same-edge reserve and writeback to r3: set wins
    applyStimulus(1, 5'd3, 64'h33, 0, 5'd0, 64'd0, 1, 5'd3, 5'd0, 5'd0);
    idleStep(5'd3);
    checkOutput("r3_set_wins", {63'd0, busy_vec[3]}, 64'd1);
    applyStimulus(0, 5'd0, 64'd0, 1, 5'd3, 64'h34, 0, 5'd0, 5'd0, 5'd0);

    // zero register is never reserved nor written
    applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd31, 5'd31, 5'd31);
    applyStimulus(1, 5'd31, 64'h3131, 0, 5'd0, 64'd0, 0, 5'd0, 5'd31, 5'd0);
    idleStep(5'd31);
    checkOutput("zero_busy", {32'd0, busy_vec}, 64'd0);

    // contended acceptance moves pointer to wb1, then reset right after the edge
    applyStimulus(0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 1, 5'd12, 5'd0, 5'd0);
    applyStimulus(1, 5'd9, 64'h99, 1, 5'd8, 64'h88, 0, 5'd0, 5'd0, 5'd0);
    checkOutput("pre_reset_we", {63'd0, RegWrite}, 64'd1);
    wb0_valid = 0; wb1_valid = 0; rsv_valid = 0;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_RegWrite", {63'd0, RegWrite}, 64'd0);
    checkOutput("mid_rst_busy", {32'd0, busy_vec}, 64'd0);
    checkOutput("mid_rst_WriteRegister", {59'd0, WriteRegister}, 64'd0);
    expQ.delete();
    mbusy = '0;
    mptr = 0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 0, 5'd0, 5'd0, 5'd0);
    checkOutput("post_rst_favour_wb0", {63'd0, obsR0}, 64'd1);

    // random traffic obeying the hold-until-ready handshake
    p0v = 0; p1v = 0;
    for (int i = 0; i < 40; i++) begin
      if (!p0v) begin
        p0v = ($urandom_range(0, 2) != 0);
        p0 = '{reg_addr: 5'($urandom_range(0, 31)), data: {$urandom, $urandom}};
      end
      if (!p1v) begin
        p1v = ($urandom_range(0, 2) != 0);
        p1 = '{reg_addr: 5'($urandom_range(0, 31)), data: {$urandom, $urandom}};
      end
      applyStimulus(p0v, p0.reg_addr, p0.data, p1v, p1.reg_addr, p1.data,
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (mAcc0) p0v = 0;
      if (mAcc1) p1v = 0;
    end
    idleStep(5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
